// File: rtl/apb_ram_completer_pkg.sv
// Shared widths, FSM state and error-cause encoding for the APB RAM completer.
package apb_ram_completer_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int APB_PROT_WIDTH = 3;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  // Priority order when several causes apply: misaligned, range, protection.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGNED,
    ERR_RANGE,
    ERR_PROT
  } err_cause_e;

endpackage

// File: rtl/apb_ram_completer_if.sv
// APB4 bus between one requester and one completer (one PSEL per completer).
interface apb_ram_completer_if #(
  parameter int ADDR_WIDTH = apb_ram_completer_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_ram_completer_pkg::APB_DATA_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_ram_completer_mem.sv
// Single-port word RAM: byte-enable synchronous write, asynchronous read.
module apb_ram_completer_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_ram_completer.sv
// APB4 completer fronting a byte-lane RAM, with optional wait states and PSLVERR decode.
module apb_ram_completer
  import apb_ram_completer_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int PROT_CHECK  = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_ram_completer_if.slave apb
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
  localparam logic [3:0]            WS_CNT    = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-3:0] MEM_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);

  typedef struct packed {
    logic                  write;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
    logic                  err;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_live, cur;
  err_cause_e            cause;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d, mem_rdata;
  logic                  setup, complete, abort, raise, mem_we;
  logic [1:0]            prot_unused;

  assign prot_unused = apb.pprot[2:1];

  always_comb begin
    cause = ERR_NONE;
    if (apb.paddr[1:0] != 2'b00)                                cause = ERR_MISALIGNED;
    else if (apb.paddr[ADDR_WIDTH-1:2] >= MEM_WORDS)            cause = ERR_RANGE;
    else if (PROT_CHECK != 0 && apb.pwrite && !apb.pprot[0])    cause = ERR_PROT;
  end

  assign req_live = '{write: apb.pwrite, idx: apb.paddr[IDX_WIDTH+1:2], wdata: apb.pwdata,
                      strb: apb.pstrb, err: (cause != ERR_NONE)};

  // With zero wait states the response is formed at the setup edge, before req_q is loaded.
  assign cur      = (state_q == IDLE) ? req_live : req_q;
  assign setup    = (state_q == IDLE) && apb.psel && !apb.penable;
  assign complete = (state_q == ACCESS) && apb.psel && apb.penable && pready_q;
  assign abort    = (state_q == ACCESS) && !(apb.psel && apb.penable);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup)              state_d = ACCESS;
      ACCESS:  if (complete || abort)  state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    raise     = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          cnt_d = WS_CNT;
          raise = (WS_CNT == 4'd0);
        end
      end
      ACCESS: begin
        if (complete || abort) begin
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          mem_we    = complete && req_q.write && !req_q.err && presetn;
        end else if (!pready_q) begin
          cnt_d = cnt_q - 4'd1;
          raise = (cnt_q == 4'd1);
        end
      end
      default: ;
    endcase
    if (raise) begin
      pready_d  = 1'b1;
      pslverr_d = cur.err;
      if (!cur.write) prdata_d = cur.err ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // The latched request is only consumed in ACCESS, which always follows a load.
  always_ff @(posedge pclk) begin
    if (setup) req_q <= req_live;
  end

  apb_ram_completer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .idx   (cur.idx),
    .be    (req_q.strb),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule
